i2c_poll_scheduler: RTL and testbench

- Sequences one i2c_poll instance across a programmable table of (device, register) slots, round-robin over enabled slots.
- For each slot: holds the poller in reset while it applies addresses, releases it, and watches its state code to detect success, address/register NACK, or timeout.
- Emits one tagged result per transaction to downstream sensor-fusion logic.
- Runs on the system clock; the poller runs on its own slow I2C clock.

---
 rtl/i2c_poll_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_poll_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_scheduler.sv
// Round-robin scheduler driving a single i2c_poll instance across a table of
// (device, register) slots; reports one tagged result per transaction.
module i2c_poll_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int SETUP_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int GAP_CYCLES     = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_slot,
    input  logic [6:0]  cfg_device,
    input  logic [7:0]  cfg_register,
    input  logic        cfg_slot_en,
    input  logic [4:0]  poll_state,
    input  logic [47:0] poll_reading,
    output logic        poll_reset,
    output logic [6:0]  poll_device_address,
    output logic [7:0]  poll_register_address,
    output logic        result_valid,
    output logic [2:0]  result_slot,
    output logic [1:0]  result_status,
    output logic [47:0] result_data,
    output logic        busy,
    output logic [2:0]  current_slot
);

    localparam int SW = (SETUP_CYCLES   > 1) ? $clog2(SETUP_CYCLES)   : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETUP, S_RUN, S_CAPTURE, S_REPORT, S_GAP
    } state_e;

    state_e state_q, state_d;

    logic [6:0]           dev_q [NUM_SLOTS];
    logic [7:0]           reg_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] en_q;

    logic [2:0]    ptr_q;
    logic [2:0]    cur_q;
    logic [6:0]    dev_addr_q;
    logic [7:0]    reg_addr_q;
    logic [2:0]    rslot_q;
    logic [1:0]    rstatus_q;
    logic [47:0]   rdata_q;
    logic          ack_phase_q;
    logic          nack_seen_q;
    logic [SW-1:0] setup_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    logic [4:0] ps_meta_q, ps_sync_q, ps_prev_q, ps_stable_q;

    logic       found;
    logic [2:0] sel_slot;
    logic [6:0] sel_dev;
    logic [7:0] sel_reg;
    logic [3:0] cand;
    logic       any_en;

    logic setup_done, gap_done, tmo_fire, nack_fire, succ_fire, ack_code;

    assign poll_device_address   = dev_addr_q;
    assign poll_register_address = reg_addr_q;
    assign result_slot           = rslot_q;
    assign result_status         = rstatus_q;
    assign result_data           = rdata_q;
    assign current_slot          = cur_q;

    assign any_en     = |en_q;
    assign setup_done = (setup_cnt_q == SW'(SETUP_CYCLES - 1));
    assign gap_done   = (gap_cnt_q == GW'(GAP_CYCLES - 1));
    assign tmo_fire   = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign ack_code   = (ps_stable_q == 5'd8) || (ps_stable_q == 5'd13) ||
                        (ps_stable_q == 5'd23);
    assign nack_fire  = (ps_stable_q == 5'd0) && ack_phase_q;
    assign succ_fire  = (ps_stable_q == 5'd31) && nack_seen_q;

    // A code is only trusted once two consecutive synchronized samples agree.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_meta_q   <= '0;
            ps_sync_q   <= '0;
            ps_prev_q   <= '0;
            ps_stable_q <= '0;
        end else begin
            ps_meta_q <= poll_state;
            ps_sync_q <= ps_meta_q;
            ps_prev_q <= ps_sync_q;
            if (ps_sync_q == ps_prev_q) begin
                ps_stable_q <= ps_sync_q;
            end
        end
    end

    // First enabled slot at or after the pointer, wrapping modulo NUM_SLOTS.
    always_comb begin
        found    = 1'b0;
        sel_slot = '0;
        sel_dev  = '0;
        sel_reg  = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= 4'(NUM_SLOTS)) begin
                cand = cand - 4'(NUM_SLOTS);
            end
            for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
                if (!found && en_q[j] && (cand[2:0] == 3'(j))) begin
                    found    = 1'b1;
                    sel_slot = 3'(j);
                    sel_dev  = dev_q[j];
                    sel_reg  = reg_q[j];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable && any_en) state_d = S_SELECT;
            S_SELECT:  state_d = found ? S_SETUP : S_IDLE;
            S_SETUP:   if (setup_done) state_d = S_RUN;
            S_RUN: begin
                if (succ_fire) begin
                    state_d = S_CAPTURE;
                end else if (nack_fire || tmo_fire) begin
                    state_d = S_REPORT;
                end
            end
            S_CAPTURE: state_d = S_REPORT;
            S_REPORT:  state_d = S_GAP;
            S_GAP:     if (gap_done) state_d = enable ? S_SELECT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        poll_reset   = 1'b1;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state_q)
            S_SETUP:   busy = 1'b1;
            S_RUN,
            S_CAPTURE: begin
                poll_reset = 1'b0;
                busy       = 1'b1;
            end
            S_REPORT:  result_valid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                dev_q[i] <= '0;
                reg_q[i] <= '0;
            end
            en_q        <= '0;
            ptr_q       <= '0;
            cur_q       <= '0;
            dev_addr_q  <= '0;
            reg_addr_q  <= '0;
            rslot_q     <= '0;
            rstatus_q   <= '0;
            rdata_q     <= '0;
            ack_phase_q <= 1'b0;
            nack_seen_q <= 1'b0;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_we && (cfg_slot == 3'(i))) begin
                    dev_q[i] <= cfg_device;
                    reg_q[i] <= cfg_register;
                    en_q[i]  <= cfg_slot_en;
                end
            end
            case (state_q)
                S_SELECT: begin
                    if (found) begin
                        dev_addr_q  <= sel_dev;
                        reg_addr_q  <= sel_reg;
                        cur_q       <= sel_slot;
                        setup_cnt_q <= '0;
                    end
                end
                S_SETUP: begin
                    setup_cnt_q <= setup_cnt_q + 1'b1;
                    ack_phase_q <= 1'b0;
                    nack_seen_q <= 1'b0;
                    to_cnt_q    <= '0;
                end
                S_RUN: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (ack_code) ack_phase_q <= 1'b1;
                    if (ps_stable_q == 5'd30) nack_seen_q <= 1'b1;
                    if (!succ_fire && (nack_fire || tmo_fire)) begin
                        rstatus_q <= nack_fire ? 2'd1 : 2'd2;
                        rdata_q   <= '0;
                        rslot_q   <= cur_q;
                    end
                end
                S_CAPTURE: begin
                    rdata_q   <= poll_reading;
                    rstatus_q <= 2'd0;
                    rslot_q   <= cur_q;
                end
                S_REPORT: begin
                    ptr_q     <= (cur_q == 3'(NUM_SLOTS - 1)) ? 3'd0 : cur_q + 3'd1;
                    gap_cnt_q <= '0;
                end
                S_GAP: gap_cnt_q <= gap_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Randomized bench: a bus model plays the poller's state codes and a table /
// round-robin reference model predicts every address, result and latency.
module tb_i2c_poll_scheduler;

    localparam int NS    = 4;
    localparam int SETUP = 16;
    localparam int TMO   = 500;
    localparam int GAP   = 20;

    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_FREEZE = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_slot = '0;
    logic [6:0]  cfg_device = '0;
    logic [7:0]  cfg_register = '0;
    logic        cfg_slot_en = 1'b0;
    logic [4:0]  poll_state = '0;
    logic [47:0] poll_reading = '0;
    logic        poll_reset;
    logic [6:0]  poll_device_address;
    logic [7:0]  poll_register_address;
    logic        result_valid;
    logic [2:0]  result_slot;
    logic [1:0]  result_status;
    logic [47:0] result_data;
    logic        busy;
    logic [2:0]  current_slot;

    i2c_poll_scheduler #(
        .NUM_SLOTS     (NS),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .enable               (enable),
        .cfg_we               (cfg_we),
        .cfg_slot             (cfg_slot),
        .cfg_device           (cfg_device),
        .cfg_register         (cfg_register),
        .cfg_slot_en          (cfg_slot_en),
        .poll_state           (poll_state),
        .poll_reading         (poll_reading),
        .poll_reset           (poll_reset),
        .poll_device_address  (poll_device_address),
        .poll_register_address(poll_register_address),
        .result_valid         (result_valid),
        .result_slot          (result_slot),
        .result_status        (result_status),
        .result_data          (result_data),
        .busy                 (busy),
        .current_slot         (current_slot)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          slot;
        int          status;
        logic [47:0] data;
        logic [6:0]  dev;
        int          start;
    } exp_t;

    logic [6:0] m_dev [NS];
    logic [7:0] m_reg [NS];
    bit         m_en  [NS];
    int         m_mode[NS];
    int         m_ptr = 0;
    exp_t       q[$];

    int rv_count = 0;
    int txn_count = 0;
    int last_start_slot = -1;
    int last_rv_cyc = 0;
    bit have_last = 1'b0;
    bit track_gap = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int next_slot();
        for (int i = 0; i < NS; i++) begin
            int s;
            s = (m_ptr + i) % NS;
            if (m_en[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_dev[i]  = '0;
            m_reg[i]  = '0;
            m_en[i]   = 1'b0;
            m_mode[i] = M_ACK;
        end
        m_ptr = 0;
        q.delete();
        have_last = 1'b0;
    endtask

    task automatic cfg_wr(input int s, input logic [6:0] d, input logic [7:0] r,
                          input bit en, input int mode);
        cfg_we       = 1'b1;
        cfg_slot     = 3'(s);
        cfg_device   = d;
        cfg_register = r;
        cfg_slot_en  = en;
        m_dev[s]  = d;
        m_reg[s]  = r;
        m_en[s]   = en;
        m_mode[s] = mode;
        @(negedge clock);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_results(input string tag, input int n, input int budget);
        int tgt;
        tgt = rv_count + n;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (rv_count >= tgt) return;
        end
        chk({"wait_", tag}, 64'(rv_count), 64'(tgt));
    endtask

    task automatic wait_start(input string tag, input int slot, input int budget);
        int base;
        base = txn_count;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (txn_count > base && (slot < 0 || last_start_slot == slot)) return;
        end
        chk({"start_", tag}, 64'(txn_count), 64'(base + 1));
    endtask

    // Holds a poller code; returns early once the poller is put back in reset.
    task automatic hold(input logic [4:0] c, input int n);
        poll_state = c;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (poll_reset) return;
        end
    endtask

    task automatic run_seq(input int mode);
        hold(5'd0, $urandom_range(6, 2));
        case (mode)
            M_ACK: begin
                hold(5'd8,  $urandom_range(8, 4));
                hold(5'd13, $urandom_range(8, 4));
                hold(5'd23, $urandom_range(8, 4));
                hold(5'd30, $urandom_range(8, 4));
                hold(5'd31, 1000);
            end
            M_NACK: begin
                hold(5'd8, $urandom_range(8, 4));
                hold(5'd0, 1000);
            end
            default: hold(5'd9, TMO + 200);
        endcase
    endtask

    initial begin : bus_model
        bit          prev;
        int          s;
        exp_t        e;
        logic [63:0] r;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (prev && !poll_reset) begin
                s = next_slot();
                txn_count++;
                last_start_slot = s;
                if (s < 0) begin
                    chk("slot_found", 64'(0), 64'(1));
                    hold(5'd0, 1000);
                end else begin
                    chk("dev_addr", 64'(poll_device_address), 64'(m_dev[s]));
                    chk("reg_addr", 64'(poll_register_address), 64'(m_reg[s]));
                    chk("cur_slot", 64'(current_slot), 64'(s));
                    if (track_gap && have_last)
                        chk("gap_latency", 64'(cyc - last_rv_cyc), 64'(GAP + SETUP + 2));
                    r = {$urandom(), $urandom()};
                    poll_reading = r[47:0];
                    e.slot   = s;
                    e.status = (m_mode[s] == M_ACK) ? 0 : (m_mode[s] == M_NACK) ? 1 : 2;
                    e.data   = (m_mode[s] == M_ACK) ? r[47:0] : 48'd0;
                    e.dev    = m_dev[s];
                    e.start  = cyc;
                    q.push_back(e);
                    m_ptr = (s + 1) % NS;
                    run_seq(m_mode[s]);
                end
                chk("poll_released", 64'(poll_reset), 64'(1));
                repeat (2) @(negedge clock);
                poll_state = 5'd0;
            end
            prev = poll_reset;
        end
    end

    initial begin : result_monitor
        bit   rv_pending;
        exp_t e;
        rv_pending = 1'b0;
        forever begin
            @(negedge clock);
            if (rv_pending) begin
                chk("pulse_len", 64'(result_valid), 64'(0));
                rv_pending = 1'b0;
            end
            if (reset && result_valid) begin
                rv_count++;
                rv_pending  = 1'b1;
                last_rv_cyc = cyc;
                have_last   = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("res_slot", 64'(result_slot), 64'(e.slot));
                    chk("res_status", 64'(result_status), 64'(e.status));
                    chk("res_data", 64'(result_data), 64'(e.data));
                    chk("dev_held", 64'(poll_device_address), 64'(e.dev));
                    chk("report_prst", 64'(poll_reset), 64'(1));
                    if (e.status == 2)
                        chk("tmo_latency", 64'(cyc - e.start), 64'(TMO));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int pick;
        model_clear();

        #2;
        chk("rst_poll_reset", 64'(poll_reset), 64'(1));
        chk("rst_dev", 64'(poll_device_address), 64'(0));
        chk("rst_reg", 64'(poll_register_address), 64'(0));
        chk("rst_valid", 64'(result_valid), 64'(0));
        chk("rst_res", 64'({result_slot, result_status, result_data}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cur", 64'(current_slot), 64'(0));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;

        cfg_wr(0, 7'h68, 8'h3B, 1'b1, M_ACK);
        cfg_wr(1, 7'h50, 8'h10, 1'b0, M_NACK);
        cfg_wr(2, 7'h0C, 8'h03, 1'b1, M_ACK);
        cfg_wr(3, 7'h22, 8'h44, 1'b0, M_ACK);
        track_gap = 1'b1;
        enable = 1'b1;
        wait_results("alt", 4, 2000);

        // Slot 1 joins and NACKs its device address.
        wait_start("nack_join", -1, 2000);
        cfg_wr(1, 7'h50, 8'h10, 1'b1, M_NACK);
        wait_results("nack", 3, 2000);

        // Rewrite slot 0 while its own transaction is running.
        wait_start("rewrite", 0, 2000);
        cfg_wr(0, 7'h1E, 8'h3B, 1'b1, M_ACK);
        wait_results("rewrite", 4, 3000);

        m_mode[1] = M_FREEZE;
        wait_results("timeout", 2, 4000);

        for (int round = 0; round < 2; round++) begin
            wait_start("rand_cfg", -1, 4000);
            pick = $urandom_range(NS - 1, 0);
            for (int s = 0; s < NS; s++) begin
                bit en;
                en = (round == 0) ? (($urandom_range(1, 0) == 1) || (s == pick)) : (s == pick);
                cfg_wr(s, 7'($urandom_range(127, 0)), 8'($urandom_range(255, 0)), en,
                       $urandom_range(M_NACK, M_ACK));
            end
            wait_results("rand", (round == 0) ? 8 : 3, 4000);
        end

        // Dropping enable mid-run lets exactly one result out.
        track_gap = 1'b0;
        wait_start("drop", -1, 2000);
        enable = 1'b0;
        base = rv_count;
        wait_results("drop", 1, 2000);
        repeat (GAP + SETUP + 40) @(negedge clock);
        #1;
        chk("drop_count", 64'(rv_count), 64'(base + 1));
        chk("drop_busy", 64'(busy), 64'(0));
        chk("drop_prst", 64'(poll_reset), 64'(1));

        // Asynchronous reset in the middle of RUN.
        have_last = 1'b0;
        enable = 1'b1;
        wait_start("rst_mid", -1, 2000);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_prst", 64'(poll_reset), 64'(1));
        chk("mid_rst_valid", 64'(result_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_dev", 64'(poll_device_address), 64'(0));
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        base = rv_count;
        repeat (60) @(negedge clock);
        #1;
        chk("post_rst_idle_results", 64'(rv_count), 64'(base));
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_prst", 64'(poll_reset), 64'(1));
        cfg_wr(3, 7'h33, 8'h77, 1'b1, M_ACK);
        wait_results("post_rst", 1, 2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
